// File: rtl/somador_subtrator_full_adder.sv
// One-bit full adder cell; the top level chains WIDTH of these into a
// ripple-carry adder.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/somador_subtrator.sv
// Registered unsigned adder/subtractor: select=1 gives a+b, select=0 gives a-b.
// Both operations share one ripple-carry chain. The result register is cleared asynchronously.
module somador_subtrator #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             select,
   output logic [WIDTH:0]   resul
);

   logic             sub;
   logic [WIDTH-1:0] b_mod;
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum;
   logic [WIDTH:0]   next_resul;

   // Subtraction is a + ~b + 1. Operand B is inverted and the carry-in is set when select is low.
   assign sub      = ~select;
   assign b_mod    = b ^ {WIDTH{sub}};
   assign carry[0] = sub;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chain
      full_adder u_fa (
         .a    (a[i]),
         .b    (b_mod[i]),
         .cin  (carry[i]),
         .sum  (sum[i]),
         .cout (carry[i+1])
      );
   end

   // The top bit is the carry on add and the inverted carry (borrow) on subtract.
   assign next_resul = {carry[WIDTH] ^ sub, sum};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) resul <= '0;
      else       resul <= next_resul;
   end

endmodule

// File: tb/tb_somador_subtrator.sv
// Directed self-checking bench for somador_subtrator at WIDTH=4.
module tb_somador_subtrator;

   logic       clock;
   logic       reset;
   logic [3:0] a;
   logic [3:0] b;
   logic       select;
   logic [4:0] resul;
   int         checks;
   int         errors;

   somador_subtrator #(.WIDTH(4)) dut (
      .clock  (clock),
      .reset  (reset),
      .a      (a),
      .b      (b),
      .select (select),
      .resul  (resul)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input logic [4:0] exp, input string tag);
      checks++;
      assert (resul === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, resul, exp);
      end
   endtask

   // Drive the inputs on the falling edge and check one clock later.
   task automatic step(input logic [3:0] ta, input logic [3:0] tb, input logic ts,
                       input logic [4:0] exp, input string tag);
      @(negedge clock);
      a = ta; b = tb; select = ts;
      @(posedge clock);
      #1;
      check(exp, tag);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      a = 4'd7; b = 4'd5; select = 1'b1;
      reset = 1'b1;
      #1;
      check(5'd0, "reset_async");
      @(posedge clock); #1;
      check(5'd0, "reset_hold1");
      @(posedge clock); #1;
      check(5'd0, "reset_hold2");
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      check(5'd12, "release_7p5");

      step(4'd0,  4'd0,  1'b1, 5'd0,  "add_0p0");
      step(4'd1,  4'd0,  1'b1, 5'd1,  "add_1p0");
      step(4'd1,  4'd2,  1'b1, 5'd3,  "add_1p2");
      step(4'd3,  4'd1,  1'b1, 5'd4,  "add_3p1");
      step(4'd15, 4'd1,  1'b1, 5'd16, "add_15p1");
      step(4'd15, 4'd15, 1'b1, 5'd30, "add_15p15");

      step(4'd3,  4'd1,  1'b0, 5'd2,  "sub_3m1");
      step(4'd1,  4'd1,  1'b0, 5'd0,  "sub_1m1");
      step(4'd4,  4'd1,  1'b0, 5'd3,  "sub_4m1");
      step(4'd15, 4'd0,  1'b0, 5'd15, "sub_15m0");
      step(4'd1,  4'd3,  1'b0, 5'b11110, "sub_1m3");
      step(4'd0,  4'd15, 1'b0, 5'b10001, "sub_0m15");
      step(4'd0,  4'd1,  1'b0, 5'b11111, "sub_0m1");

      step(4'd9, 4'd4, 1'b1, 5'd13, "b2b_add1");
      step(4'd9, 4'd4, 1'b0, 5'd5,  "b2b_sub1");
      step(4'd9, 4'd4, 1'b1, 5'd13, "b2b_add2");
      step(4'd9, 4'd4, 1'b0, 5'd5,  "b2b_sub2");

      // A mid-stream reset clears the output at once, and results resume after release.
      #2;
      reset = 1'b1;
      #1;
      check(5'd0, "midreset_async");
      @(posedge clock); #1;
      check(5'd0, "midreset_hold");
      @(negedge clock);
      reset = 1'b0;
      a = 4'd9; b = 4'd4; select = 1'b1;
      @(posedge clock); #1;
      check(5'd13, "resume_add");
      step(4'd9, 4'd4, 1'b0, 5'd5, "resume_sub");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/somador_subtrator.md
Name: somador_subtrator

Overview:
- Registered 4-bit unsigned adder/subtractor with a single `select` control: 1 = add, 0 = subtract.
- Produces a 5-bit result: carry-out on add, borrow/sign on subtract.
- Arithmetic leaf used by datapath blocks (coordinate/counter updates); the output is registered for clean timing into downstream logic.

Parameters:
- WIDTH, 4, operand width in bits; result width is WIDTH+1.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears the output register.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- select  input  1  operation: 1 = a+b, 0 = a-b.
- resul  output  WIDTH+1  registered result.

Behaviour:
- Reset: while reset=1 (asynchronous assert), resul = 0. Release is synchronous to the next rising clock edge.
- Latency: resul reflects the a/b/select values sampled at the previous rising edge, i.e. 1 cycle. No handshake; a new operation is accepted every cycle.
- Add (select=1): resul = {1'b0,a} + {1'b0,b}.
  - Full WIDTH+1 bits, no truncation.
  - Bit WIDTH is the carry-out.
  - Range 0..2^(WIDTH+1)-2 (max 30 at WIDTH=4).
- Subtract (select=0): resul = ({1'b0,a} - {1'b0,b}) mod 2^(WIDTH+1).
  - Implemented as a + ~b + 1 through the same carry chain.
  - Bit WIDTH = NOT(carry-out), i.e. the borrow/sign bit.
  - a>=b gives the plain difference with bit WIDTH = 0.
  - a<b gives the WIDTH+1-bit two's complement with bit WIDTH = 1 (e.g. 1-3 = 5'b11110).
- Single datapath: one carry chain for both operations.
  - b is XORed with select-inverted (~select).
  - Carry-in = ~select.
- No saturation, no overflow flag; results never wrap at WIDTH+1 bits on add.
- select or operands changing every cycle: each cycle's result depends only on that cycle's sampled inputs; there is no internal state other than the output register.
- Reset asserted mid-stream:
  - resul goes to 0 immediately.
  - Inputs present at the first edge after release are computed normally.
- X-free: every output bit is driven from the register in all states.

Decomposition:
- No shared package is needed. WIDTH is the only constant and is local to the block.
- One natural sub-module: full_adder (1-bit a, b, cin -> sum, cout), instantiated WIDTH times in a generate loop to form the ripple-carry chain.
- The top level holds the operand-inversion logic, borrow/carry-out mapping and the output register.

Test Plan:
- Reset: assert reset with a=4'd7, b=4'd5, select=1 -> resul=0 immediately, without waiting for a clock edge; it stays 0 while reset is held.
- Add basics: (0+0)->0, (1+0)->1, (1+2)->3, (3+1)->4, each visible one clock after the inputs are applied.
- Add carry/max: (15+1)->5'd16; (15+15)->5'd30.
- Subtract basics: (3-1)->2, (1-1)->0, (4-1)->3, (15-0)->15; bit4 = 0 in every case.
- Subtract negative: (1-3)->5'b11110; (0-15)->5'b10001; (0-1)->5'b11111.
- Back-to-back: toggle select every cycle with a=9, b=4 -> resul alternates 13, 5, 13, 5 with 1-cycle latency. Then pulse reset mid-sequence -> resul=0, and correct results resume from the first edge after release.
